// File: rtl/space_bg_scroll_fetch.sv
// space_bg_scroll_fetch
// Turns VGA draw coordinates into a background ROM address. The background is
// 4-bit indexed, scaled up by 2^SCALE_SHIFT and tiled vertically with a
// frame-paced vertical scroll. The block registers the ROM data and hands a
// palette index, aligned to the pipeline, plus a valid flag to the palette.
//
// Pipeline (one pixel accepted every clock, with no backpressure):
//   edge 1 : rom_addr and v1 registered from DrawX/DrawY/pix_active
//   edge 2 : v2 <= v1, and the synchronous ROM presents rom_q
//   edge 3 : index_out and index_valid registered
// The total latency is 3 clocks, so the consumer delays hsync/vsync by 3.

module space_bg_scroll_fetch #(
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned SCROLL_DIV  = 4,
  parameter int unsigned BLANK_INDEX = 6,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_active,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index_out,
  output logic              index_valid,
  output logic [6:0]        scroll_pos
);

  // With SCROLL_DIV=1 the divider never counts. Keep it one bit wide so the
  // vector stays legal.
  localparam int unsigned FDIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [FDIV_W-1:0] FDIV_LAST = FDIV_W'(SCROLL_DIV - 1);
  localparam logic [6:0]        POS_LAST  = 7'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_H_A   = ADDR_W'(IMG_H);
  localparam logic [3:0]        BLANK     = 4'(BLANK_INDEX);

  logic [FDIV_W-1:0] fdiv;

  // Address-stage combinational values. All of them are ADDR_W wide, so the
  // row*IMG_W product cannot truncate for in-range inputs.
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] row_sum;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] addr_next;
  logic              in_rng;
  logic              take;

  // Pipeline valid bits.
  logic v1;
  logic v2;

  // Scroll counter. It moves only on enabled frame_start pulses, so it holds
  // steady through the visible frame.
  // NOTE: state is updated with non-blocking assignments, so every register
  // samples the pre-edge values. Reset is asynchronous and lives in the
  // sensitivity list.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fdiv       <= '0;
      scroll_pos <= '0;
    end else if (frame_start && scroll_en) begin
      if (fdiv == FDIV_LAST) begin
        fdiv       <= '0;
        scroll_pos <= (scroll_pos == POS_LAST) ? 7'd0 : scroll_pos + 7'd1;
      end else begin
        fdiv <= fdiv + 1'b1;
      end
    end
  end

  // Scale the coordinates down, apply the vertical scroll with a single
  // conditional wrap, and form the linear ROM address.
  // NOTE: every always_comb output gets a default first, so no path can infer
  // a latch.
  always_comb begin
    col       = '0;
    r         = '0;
    row_sum   = '0;
    row       = '0;
    addr_next = '0;
    in_rng    = 1'b0;
    col       = ADDR_W'(DrawX >> SCALE_SHIFT);
    r         = ADDR_W'(DrawY >> SCALE_SHIFT);
    in_rng    = (col < IMG_W_A) && (r < IMG_H_A);
    // r < IMG_H and scroll_pos < IMG_H, so the sum is below 2*IMG_H and one
    // subtraction is enough to wrap it.
    row_sum   = r + ADDR_W'(scroll_pos);
    row       = (row_sum >= IMG_H_A) ? row_sum - IMG_H_A : row_sum;
    addr_next = row * IMG_W_A + col;
  end

  assign take = pix_active && in_rng;

  // Address stage. The address only moves for visible, in-image pixels, so
  // the ROM input stays still during blanking and on the image margin.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      v1       <= 1'b0;
    end else begin
      if (take) begin
        rom_addr <= addr_next;
      end
      v1 <= take;
    end
  end

  // ROM stage. This carries the valid bit alongside the synchronous ROM
  // read latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
    end
  end

  // Output stage. Registers the ROM data for valid pixels and the blank
  // (black) entry otherwise.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      index_out   <= BLANK;
      index_valid <= 1'b0;
    end else begin
      index_out   <= v2 ? rom_q : BLANK;
      index_valid <= v2;
    end
  end

endmodule

// File: tb/tb_space_bg_scroll_fetch.sv
// Directed testbench for space_bg_scroll_fetch with its default parameters.
// The ROM model is synchronous and returns rom_addr[3:0] one clock after the
// address. Inputs change on the falling edge, and outputs are sampled there
// as well.

module tb_space_bg_scroll_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        scroll_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_active;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  index_out;
  logic        index_valid;
  logic [6:0]  scroll_pos;

  int n_vec = 0;
  int n_err = 0;

  space_bg_scroll_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .scroll_en  (scroll_en),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pix_active (pix_active),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index_out  (index_out),
    .index_valid(index_valid),
    .scroll_pos (scroll_pos)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM model: the data for an address appears one clock later.
  always @(posedge Clk) rom_q <= rom_addr[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic en);
    frame_start = 1'b1;
    scroll_en   = en;
    @(negedge Clk);
    frame_start = 1'b0;
    scroll_en   = 1'b0;
  endtask

  // Flush the pipeline, present one pixel for one clock, then check the
  // address after 1 clock and the index after 3 clocks.
  task automatic one_pixel(input string tag, input int x, input int y,
                           input int exp_addr, input int exp_idx, input logic exp_valid);
    pix_active = 1'b0;
    repeat (4) @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_active = 1'b1;
    @(negedge Clk);
    pix_active = 1'b0;
    check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    @(negedge Clk);
    check({tag, ".early_valid"}, 32'(index_valid), 32'd0);
    @(negedge Clk);
    check({tag, ".idx"},   32'(index_out),   32'(exp_idx));
    check({tag, ".valid"}, 32'(index_valid), 32'(exp_valid));
  endtask

  int exp_seq[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int vcount;

  initial begin
    Reset = 1'b1;
    frame_start = 1'b0;
    scroll_en = 1'b0;
    DrawX = 10'd100;
    DrawY = 10'd100;
    pix_active = 1'b1;

    // Reset with an active pixel on the inputs. The pixel maps to col 25,
    // row 25, so the address is 25*160+25=4025 and 4025 & 15 = 9.
    repeat (3) @(negedge Clk);
    check("rst.idx",   32'(index_out),   32'd6);
    check("rst.valid", 32'(index_valid), 32'd0);
    check("rst.pos",   32'(scroll_pos),  32'd0);
    check("rst.addr",  32'(rom_addr),    32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rel.addr",   32'(rom_addr),    32'd4025);
    check("rel.valid1", 32'(index_valid), 32'd0);
    @(negedge Clk);
    check("rel.valid2", 32'(index_valid), 32'd0);
    @(negedge Clk);
    check("rel.valid3", 32'(index_valid), 32'd1);
    check("rel.idx3",   32'(index_out),   32'd9);

    // Basic pixel: col 2, row 1 gives address 162 and index 2.
    one_pixel("basic", 8, 4, 162, 2, 1'b1);

    // Scroll divider: 8 enabled pulses, then disabled pulses that must hold.
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1);
      check($sformatf("scroll%0d", i), 32'(scroll_pos), 32'(exp_seq[i]));
    end
    repeat (4) pulse(1'b0);
    check("hold.pos", 32'(scroll_pos), 32'd2);
    // The divider must also have held, so the step lands on the 4th pulse.
    repeat (3) pulse(1'b1);
    check("hold.fdiv3", 32'(scroll_pos), 32'd2);
    pulse(1'b1);
    check("hold.fdiv4", 32'(scroll_pos), 32'd3);

    // frame_start while pixels stream. The pixel sampled on the pulse edge
    // uses the old scroll; the next pixel uses the new one.
    repeat (3) pulse(1'b1);
    check("mid.pre", 32'(scroll_pos), 32'd3);
    DrawX = 10'd4;
    DrawY = 10'd0;
    pix_active  = 1'b1;
    frame_start = 1'b1;
    scroll_en   = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    scroll_en   = 1'b0;
    check("mid.addr_old", 32'(rom_addr), 32'd481);
    @(negedge Clk);
    check("mid.addr_new", 32'(rom_addr),   32'd641);
    check("mid.pos",      32'(scroll_pos), 32'd4);
    pix_active = 1'b0;

    // Wrap: reset, then 476 enabled pulses bring scroll_pos to 119.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (476) pulse(1'b1);
    check("wrap.pos119", 32'(scroll_pos), 32'd119);
    // Row 2+119-120=1 and col 5 give 160+5=165.
    one_pixel("wrap.row1", 20, 8, 165, 5, 1'b1);
    // Row 119+119-120=118 and col 159 give 18880+159=19039 (index 15).
    one_pixel("corner", 639, 479, 19039, 15, 1'b1);
    // Out of image. The address holds, and the index is blank and not valid.
    one_pixel("oob.col", 640, 0, 19039, 6, 1'b0);
    one_pixel("oob.row", 0, 480, 19039, 6, 1'b0);
    repeat (3) pulse(1'b1);
    check("wrap.pre", 32'(scroll_pos), 32'd119);
    pulse(1'b1);
    check("wrap.zero", 32'(scroll_pos), 32'd0);

    // Stream one full line (row 0, scroll 0). The index is col & 15, and the
    // trailing inactive pixels are blank. Each output appears 3 clocks later.
    vcount = 0;
    DrawY = 10'd0;
    for (int c = 0; c < 647; c++) begin
      if (c >= 3) begin
        if (c - 3 < 640) begin
          check($sformatf("line.idx%0d", c - 3), 32'(index_out), 32'(((c - 3) >> 2) & 15));
          check($sformatf("line.v%0d", c - 3), 32'(index_valid), 32'd1);
        end else begin
          check($sformatf("line.idx%0d", c - 3), 32'(index_out), 32'd6);
          check($sformatf("line.v%0d", c - 3), 32'(index_valid), 32'd0);
        end
        if (index_valid) vcount++;
      end
      pix_active = (c < 640);
      DrawX = (c < 640) ? 10'(c) : 10'd0;
      @(negedge Clk);
    end
    check("line.count", 32'(vcount), 32'd640);

    // Reset between edges with pixels in flight.
    DrawX = 10'd40;
    DrawY = 10'd40;
    pix_active = 1'b1;
    repeat (3) @(negedge Clk);
    check("inflight.valid", 32'(index_valid), 32'd1);
    #2 Reset = 1'b1;
    pix_active = 1'b0;
    #1;
    check("async.valid", 32'(index_valid), 32'd0);
    check("async.idx",   32'(index_out),   32'd6);
    check("async.addr",  32'(rom_addr),    32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("stale%0d.valid", i), 32'(index_valid), 32'd0);
      check($sformatf("stale%0d.idx", i),   32'(index_out),   32'd6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/space_bg_scroll_fetch.md
Name: space_bg_scroll_fetch

Overview:
- Upstream feeder for the 16-entry space-background palette.
- Converts VGA draw coordinates into a ROM address for a 4-bit-indexed background image, scaled up by 2^SCALE_SHIFT and tiled vertically with a frame-driven vertical scroll.
- Registers the ROM output and delivers a pipeline-aligned palette index plus valid flag to the palette lookup.
- Sits between the VGA controller / background ROM and the palette.

Parameters:
- IMG_W, 160, source image width in pixels.
- IMG_H, 120, source image height in pixels.
- SCALE_SHIFT, 2, screen-to-image downscale (640x480 maps to 160x120).
- SCROLL_DIV, 4, frames per one-row scroll step; legal range is at least 1.
- BLANK_INDEX, 6, index driven when not valid (black entry of the space palette).
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse once per frame, during vertical blanking.
- scroll_en  in  1  allows scroll advance.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- pix_active  in  1  high when DrawX/DrawY lie in the visible area.
- rom_addr  out  ADDR_W  background ROM read address (registered).
- rom_q  in  4  ROM data; valid exactly 1 clock after rom_addr.
- index_out  out  4  palette index to the palette stage.
- index_valid  out  1  index_out corresponds to a visible, in-image pixel.
- scroll_pos  out  7  current vertical scroll offset, range 0..IMG_H-1.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high and is honoured in every state.
- Reset values: rom_addr=0, index_out=BLANK_INDEX, index_valid=0, scroll_pos=0, frame divider fdiv=0, all pipeline valid bits=0.
- Scroll counter, per frame_start:
  - If scroll_en=1 on the same cycle as frame_start: when fdiv==SCROLL_DIV-1, set fdiv to 0 and advance scroll_pos by 1 (from IMG_H-1 it wraps to 0); otherwise increment fdiv.
  - If scroll_en=0: fdiv and scroll_pos hold.
  - scroll_pos changes only on frame_start cycles, so it is stable for the whole visible frame.
  - With SCROLL_DIV=1, every enabled frame_start advances scroll_pos.
- Address stage (edge 1):
  - col = DrawX >> SCALE_SHIFT; r = DrawY >> SCALE_SHIFT.
  - row = r + scroll_pos; if row >= IMG_H, subtract IMG_H (single conditional subtract; r < IMG_H is guaranteed by the in-range check).
  - in_rng = (col < IMG_W) and (r < IMG_H).
  - rom_addr <= row*IMG_W + col when pix_active and in_rng; otherwise rom_addr holds its previous value.
  - v1 <= pix_active & in_rng.
  - All arithmetic is unsigned and sized to ADDR_W; no truncation is legal for in-range inputs.
- ROM stage (edge 2): v2 <= v1. rom_q for the edge-1 address is present during this cycle.
- Output stage (edge 3):
  - index_out <= v2 ? rom_q : BLANK_INDEX.
  - index_valid <= v2.
- Total latency: DrawX/DrawY/pix_active sampled at edge 0 produce index_out at edge 3, i.e. 3 clocks. The consumer delays hsync/vsync by 3 clocks to match.
- Out-of-image pixels inside the visible area (col >= IMG_W) produce BLANK_INDEX with index_valid=0.
- frame_start during pix_active: accepted. The scroll update takes effect from the next sampled pixel; pixels already in the pipeline are unaffected.
- Reset mid-pipeline: all in-flight pixels are discarded; outputs show their reset values at the latest 1 clock after Reset rises.
- No backpressure: one pixel is accepted every clock.

Test Plan:
- Reset pulse with pix_active=1, DrawX=100, DrawY=100 -> index_out=6, index_valid=0, scroll_pos=0 while Reset=1; first valid output appears 3 clocks after release.
- scroll_pos=0, DrawX=8, DrawY=4, pix_active=1 -> rom_addr=162 at edge 1; with ROM model rom_q=addr[3:0], index_out=2 and index_valid=1 at edge 3.
- scroll_en=1, SCROLL_DIV=4, 8 frame_start pulses -> scroll_pos goes 0,0,0,1,1,1,1,2; scroll_en=0 during further pulses -> scroll_pos holds at 2.
- Wrap: scroll_pos forced to 119 via 476 enabled pulses, DrawY=8 -> row=(2+119)-120=1, rom_addr=160+col; one more scroll step -> scroll_pos=0.
- Streaming 640 pixels of one line back-to-back -> 640 consecutive index_valid=1 outputs; pix_active=0 pixels yield index_out=6, index_valid=0, each exactly 3 clocks later.
- Reset asserted asynchronously between edges with 3 pixels in flight -> index_valid drops immediately, and no stale index appears after Reset is released.
